// File: rtl/gpr_writeback_pkg.sv
// Shared types and constants for the GPR write-side front end.
// Pure declarations: no latency, no flow control.
package gpr_writeback_pkg;

  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_DATA_WIDTH = 64;

  localparam logic [GPR_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/gpr_writeback_if.sv
// Bundle of ALU/load/issue/hazard/register-file signals around gpr_writeback.
// Slave is the writeback block; master is the core-side driver (decode, ALU, LSU).
interface gpr_writeback_if
  import gpr_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH = GPR_DATA_WIDTH
);

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;

  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;

  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rs1_fwd_valid;
  logic                  rs2_fwd_valid;
  logic [DATA_WIDTH-1:0] rs1_fwd_data;
  logic [DATA_WIDTH-1:0] rs2_fwd_data;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  logic [2:0]            outstanding;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  iss_valid, iss_rd,
    output iss_ready,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy,
    output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data,
    output rf_wen, rf_waddr, rf_wdata,
    output outstanding
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output iss_valid, iss_rd,
    input  iss_ready,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy,
    input  rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data,
    input  rf_wen, rf_waddr, rf_wdata,
    input  outstanding
  );

endinterface

// File: rtl/gpr_writeback_scoreboard.sv
// Busy bit per GPR plus outstanding-load counter; busy queries are combinational.
// Issue/retire take effect at the next edge; iss_ready stalls issue when full or rd busy.
module gpr_scoreboard
  import gpr_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH      = GPR_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  ret_valid,
  input  logic [ADDR_WIDTH-1:0] ret_rd,
  input  logic [ADDR_WIDTH-1:0] q1_addr,
  output logic                  q1_busy,
  input  logic [ADDR_WIDTH-1:0] q2_addr,
  output logic                  q2_busy,
  output logic [2:0]            outstanding
);

  localparam int         NREG    = 1 << ADDR_WIDTH;
  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [2:0]      cnt_nxt;
  logic            issue;

  // Slot check uses this cycle's count, so a same-cycle retire never frees it early.
  assign iss_ready = (outstanding < MAX_CNT) && ((iss_rd == '0) || !busy[iss_rd]);
  assign issue     = iss_valid && iss_ready;

  assign q1_busy = (q1_addr != '0) && busy[q1_addr];
  assign q2_busy = (q2_addr != '0) && busy[q2_addr];

  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = outstanding;
    if (ret_valid) begin
      busy_nxt[ret_rd] = 1'b0;
    end
    if (issue && (iss_rd != '0)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    case ({issue, ret_valid})
      2'b10:   cnt_nxt = outstanding + 3'd1;
      2'b01:   cnt_nxt = outstanding - 3'd1;
      default: cnt_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_nxt;
      outstanding <= cnt_nxt;
    end
  end

endmodule

// File: rtl/gpr_writeback.sv
// Merges ALU and load results into one registered GPR write port; 1-cycle accept-to-rf_wen.
// ALU never stalls; loads see ld_ready low whenever the ALU writes and must hold.
module gpr_writeback
  import gpr_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH      = GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH      = GPR_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  gpr_writeback_if.slave  wb
);

  wb_src_e               src;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  ld_acc;

  assign wb.ld_ready = !wb.alu_valid;
  assign ld_acc      = wb.ld_valid && !wb.alu_valid;

  always_comb begin
    src      = WB_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (wb.alu_valid) begin
      src      = WB_ALU;
      sel_rd   = wb.alu_rd;
      sel_data = wb.alu_data;
    end else if (ld_acc) begin
      src      = WB_LD;
      sel_rd   = wb.ld_rd;
      sel_data = wb.ld_data;
    end
  end

  // x0 writes still load address/data; only the enable is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.rf_wen   <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
    end else begin
      wb.rf_wen <= (src != WB_NONE) && (sel_rd != REG_ZERO);
      if (src != WB_NONE) begin
        wb.rf_waddr <= sel_rd;
        wb.rf_wdata <= sel_data;
      end
    end
  end

  assign wb.rs1_fwd_valid = wb.rf_wen && (wb.rf_waddr == wb.rs1_addr) && (wb.rs1_addr != REG_ZERO);
  assign wb.rs2_fwd_valid = wb.rf_wen && (wb.rf_waddr == wb.rs2_addr) && (wb.rs2_addr != REG_ZERO);
  assign wb.rs1_fwd_data  = wb.rf_wdata;
  assign wb.rs2_fwd_data  = wb.rf_wdata;

  gpr_scoreboard #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (wb.iss_valid),
    .iss_rd      (wb.iss_rd),
    .iss_ready   (wb.iss_ready),
    .ret_valid   (ld_acc),
    .ret_rd      (wb.ld_rd),
    .q1_addr     (wb.rs1_addr),
    .q1_busy     (wb.rs1_busy),
    .q2_addr     (wb.rs2_addr),
    .q2_busy     (wb.rs2_busy),
    .outstanding (wb.outstanding)
  );

endmodule

// File: doc/gpr_writeback.md
Name: gpr_writeback

Overview:
- Write-side front end of the GPR file.
- Merges single-cycle ALU results and multi-cycle load results into one registered write port (`rf_wen`/`rf_waddr`/`rf_wdata`) that drives the register file.
- Keeps a per-register busy scoreboard for outstanding loads, so decode can stall on hazards.
- Provides a one-cycle bypass for the write that is in flight.

Parameters:
- ADDR_WIDTH, 5, GPR index width (32 registers).
- DATA_WIDTH, 64, GPR data width.
- MAX_OUTSTANDING, 2, maximum loads issued but not yet written back (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result valid this cycle (no backpressure).
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load result accepted this cycle.
- ld_rd  in  ADDR_WIDTH  load destination register.
- ld_data  in  DATA_WIDTH  load data.
- iss_valid  in  1  decode wants to issue a load.
- iss_rd  in  ADDR_WIDTH  destination register of the issuing load.
- iss_ready  out  1  load issue accepted.
- rs1_addr, rs2_addr  in  ADDR_WIDTH  decode source registers.
- rs1_busy, rs2_busy  out  1  source register awaits a load.
- rs1_fwd_valid, rs2_fwd_valid  out  1  source matches the in-flight write.
- rs1_fwd_data, rs2_fwd_data  out  DATA_WIDTH  bypass value (equals `rf_wdata`).
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- outstanding  out  3  count of loads issued and not yet retired.

Behaviour:
- Reset, asynchronous on `rst_n`=0:
  - `rf_wen`/`rf_waddr`/`rf_wdata` are 0.
  - All busy bits are 0 and `outstanding` is 0.
  - Any in-flight loads are discarded; the LSU is reset by the same `rst_n`.
- Arbitration:
  - ALU has fixed priority over loads.
  - `ld_ready` = !`alu_valid` (combinational).
  - A load is retired on `ld_valid` && `ld_ready`.
  - A stalled load must hold `ld_rd` and `ld_data` stable until it is accepted.
- Write stage, one register deep, 1-cycle latency from acceptance to `rf_wen`:
  - The selected source loads `rf_waddr`/`rf_wdata`.
  - `rf_wen` = accepted && rd != 0.
  - Writes to x0 are dropped. `rf_waddr`/`rf_wdata` still update; `rf_wen` stays 0.
  - With no source accepted, `rf_wen` goes to 0 the next cycle. Address and data hold.
- Issue:
  - `iss_ready` = (`outstanding` < MAX_OUTSTANDING) && (`iss_rd` == 0 || !busy[`iss_rd`]).
  - `iss_ready` is computed from current-cycle state. A retirement in the same cycle does not free the slot.
  - On issue: `outstanding`++; busy[`iss_rd`] is set if `iss_rd` != 0.
- Retire:
  - `outstanding`--; busy[`ld_rd`] is cleared.
  - Issue and retire in the same cycle leave `outstanding` unchanged.
  - Set and clear of the same index cannot coincide, because `iss_ready` blocks an issue to a busy rd.
- Hazard outputs:
  - `rsN_busy` = busy[`rsN_addr`], forced to 0 for x0. Combinational.
  - `rsN_fwd_valid` = `rf_wen` && `rf_waddr` == `rsN_addr` && `rsN_addr` != 0.
- Protocol violations (bench assertions, no recovery logic):
  - `alu_valid` with a busy `alu_rd` (WAW).
  - A load retired with rd != 0 whose busy bit is clear.
  - A retire when `outstanding` == 0.
  - `outstanding` exceeding MAX_OUTSTANDING.
- Reset mid-operation:
  - Outputs clear immediately (asynchronous).
  - The first write after `rst_n` deassert can occur in the cycle after the first accepted source.

Decomposition:
- Shared package:
  - GPR_ADDR_WIDTH = 5 and GPR_DATA_WIDTH = 64.
  - REG_ZERO = 0.
  - Writeback source enum (WB_NONE, WB_ALU, WB_LD).
- One sub-module, `gpr_scoreboard`:
  - 32 busy bits plus the `outstanding` counter.
  - Issue/retire ports, two combinational busy-query ports.
  - Owns `iss_ready`.
- The top level keeps arbitration, the write register and the bypass.

Test Plan:
- ALU-only path: `alu_valid`=1, rd=5, data=0x1234 for one cycle -> next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234; the cycle after, `rf_wen`=0.
- x0 drop: ALU rd=0, data=0xFF -> `rf_wen` stays 0; `rs1_fwd_valid`=0 with `rs1_addr`=0.
- Load lifecycle with `iss_valid` rd=10, then `rs1_addr`=10:
  - Issue -> busy[10]=1, `outstanding`=1, `rs1_busy`=1.
  - `ld_valid` rd=10, data=0xDEADBEEF -> next cycle write x10 = 0xDEADBEEF, busy[10]=0, `outstanding`=0, `rs1_fwd_valid`=1.
- Collision: ALU rd=3 and load rd=7 valid in the same cycle:
  - Cycle 0: `ld_ready`=0, ALU write to x3 scheduled.
  - Cycle 1: the held load is accepted -> x3 write visible, then x7 write one cycle later.
- Issue limits with MAX_OUTSTANDING=2:
  - Issue rd=1 and rd=2 -> `outstanding`=2.
  - Third issue rd=4 -> `iss_ready`=0.
  - Issue to rd=1 while busy -> `iss_ready`=0.
  - Simultaneous issue rd=4 and retire rd=1 when `outstanding`=1 -> `outstanding` stays 1, busy[4]=1, busy[1]=0.
- Reset mid-operation: two loads outstanding, `rf_wen`=1, assert `rst_n`=0 -> `rf_wen`, `outstanding` and all busy bits read 0 the same cycle without waiting for a clock edge.
